// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing the VGA pixel-write port between draw engines.
// Grants whole bursts, clips off-screen pixels, watchdogs bursts, flags frame done.
module vga_draw_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int X_SCREEN_PIXELS = 320,
  parameter int Y_SCREEN_PIXELS = 240,
  parameter int MAX_BURST       = 4096,
  localparam int XW = $clog2(X_SCREEN_PIXELS) + 1,
  localparam int YW = $clog2(Y_SCREEN_PIXELS) + 1
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iFrameTick,
  input  logic [NUM_REQ-1:0]    iReq,
  input  logic [NUM_REQ-1:0]    iValid,
  input  logic [NUM_REQ-1:0]    iLast,
  input  logic [NUM_REQ*XW-1:0] iX,
  input  logic [NUM_REQ*YW-1:0] iY,
  input  logic [NUM_REQ*3-1:0]  iColour,
  output logic [NUM_REQ-1:0]    oGrant,
  output logic [XW-1:0]         oX,
  output logic [YW-1:0]         oY,
  output logic [2:0]            oColour,
  output logic                  oPlot,
  output logic                  oFrameDone,
  output logic                  oTimeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [XW-1:0] XLIM = XW'(X_SCREEN_PIXELS);
  localparam logic [YW-1:0] YLIM = YW'(Y_SCREEN_PIXELS);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, gidx, gidx_n, sel, cand;
  logic [CW-1:0] cnt, cnt_n;
  logic dirty, dirty_n, found, end_burst;
  logic [NUM_REQ-1:0] grant_n;
  logic [XW-1:0] x_n, gx;
  logic [YW-1:0] y_n, gy;
  logic [2:0] col_n, gc;
  logic plot_n, done_n, tout_n;

  // A frame tick only re-arms frame tracking; nothing is cleared by it.
  logic unused_tick;
  assign unused_tick = iFrameTick;

  assign gx = iX[int'(gidx)*XW +: XW];
  assign gy = iY[int'(gidx)*YW +: YW];
  assign gc = iColour[int'(gidx)*3 +: 3];

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && iReq[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gidx_n    = gidx;
    cnt_n     = cnt;
    dirty_n   = dirty;
    grant_n   = oGrant;
    x_n       = oX;
    y_n       = oY;
    col_n     = oColour;
    plot_n    = 1'b0;
    done_n    = 1'b0;
    tout_n    = 1'b0;
    end_burst = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = NUM_REQ'(1) << sel;
          gidx_n  = sel;
          cnt_n   = '0;
          dirty_n = 1'b1;
          state_n = BURST;
        end else if (dirty) begin
          done_n  = 1'b1;
          dirty_n = 1'b0;
        end
      end
      BURST: begin
        x_n   = gx;
        y_n   = gy;
        col_n = gc;
        if (!iReq[gidx]) begin
          end_burst = 1'b1;
        end else if (iValid[gidx]) begin
          cnt_n  = cnt + 1'b1;
          plot_n = (gx < XLIM) && (gy < YLIM);
          if (iLast[gidx]) begin
            end_burst = 1'b1;
          end else if (cnt == CW'(MAX_BURST - 1)) begin
            end_burst = 1'b1;
            tout_n    = 1'b1;
          end
        end
        if (end_burst) begin
          grant_n = '0;
          ptr_n   = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state_n = GAP;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      cnt        <= '0;
      dirty      <= 1'b0;
      oGrant     <= '0;
      oX         <= '0;
      oY         <= '0;
      oColour    <= '0;
      oPlot      <= 1'b0;
      oFrameDone <= 1'b0;
      oTimeout   <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gidx       <= gidx_n;
      cnt        <= cnt_n;
      dirty      <= dirty_n;
      oGrant     <= grant_n;
      oX         <= x_n;
      oY         <= y_n;
      oColour    <= col_n;
      oPlot      <= plot_n;
      oFrameDone <= done_n;
      oTimeout   <= tout_n;
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed testbench for vga_draw_arbiter (3 engines, 8-pixel watchdog).
// Each task drives one scenario and checks against hand-computed values.
module tb_vga_draw_arbiter;
  localparam int N  = 3;
  localparam int XW = 10;
  localparam int YW = 9;

  logic clk = 0;
  logic rst = 0;
  logic tick = 0;
  logic [N-1:0] req = '0, valid = '0, last = '0;
  logic [N*XW-1:0] xb = '0;
  logic [N*YW-1:0] yb = '0;
  logic [N*3-1:0] cb = '0;
  logic [N-1:0] grant;
  logic [XW-1:0] ox;
  logic [YW-1:0] oy;
  logic [2:0] oc;
  logic plot, done, tout;

  int checks = 0;
  int errors = 0;

  vga_draw_arbiter #(
    .NUM_REQ(N), .X_SCREEN_PIXELS(320), .Y_SCREEN_PIXELS(240), .MAX_BURST(8)
  ) dut (
    .iClock(clk), .iReset(rst), .iFrameTick(tick),
    .iReq(req), .iValid(valid), .iLast(last),
    .iX(xb), .iY(yb), .iColour(cb),
    .oGrant(grant), .oX(ox), .oY(oy), .oColour(oc),
    .oPlot(plot), .oFrameDone(done), .oTimeout(tout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [1:0] k, input int xv, input int yv,
                           input int cv, input logic l);
    xb[int'(k)*XW +: XW] = XW'(xv);
    yb[int'(k)*YW +: YW] = YW'(yv);
    cb[int'(k)*3 +: 3]   = 3'(cv);
    valid[k] = 1'b1;
    last[k]  = l;
  endtask

  task automatic do_reset();
    req = '0; valid = '0; last = '0; tick = 0;
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
    checks++; if (ox !== 10'd0 || oy !== 9'd0 || oc !== 3'd0) begin errors++; $display("FAIL reset_xyc: got %0d %0d %0d want 0 0 0", ox, oy, oc); end
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", plot); end
    checks++; if (done !== 1'b0 || tout !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", done, tout); end
  endtask

  task automatic test_single();
    req[1] = 1;
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_grant: got %b want 010", grant); end
    for (int i = 0; i < 4; i++) begin
      drive_pix(2'd1, 10 + i, 20, 7, i == 3);
      tick = (i == 2);
      step();
      tick = 0;
      checks++;
      if (plot !== 1'b1 || ox !== XW'(10 + i) || oy !== 9'd20 || oc !== 3'd7) begin
        errors++;
        $display("FAIL single_pix%0d: got p=%b x=%0d y=%0d c=%0d want p=1 x=%0d y=20 c=7",
                 i, plot, ox, oy, oc, 10 + i);
      end
    end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_release: got %b want 000", grant); end
    req = '0; valid = '0; last = '0;
    step();
    checks++; if (plot !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_gap: got p=%b d=%b want 0 0", plot, done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
  endtask

  task automatic test_all_three();
    logic [N-1:0] exp;
    do_reset();
    req = 3'b111;
    for (int e = 0; e < N; e++) begin
      exp = '0;
      exp[e] = 1'b1;
      step();
      checks++; if (grant !== exp) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", e, grant, exp); end
      drive_pix(2'(e), e * 10, 1, e, 1'b0);
      step();
      drive_pix(2'(e), e * 10 + 1, 1, e, 1'b1);
      step();
      checks++; if (plot !== 1'b1 || ox !== XW'(e * 10 + 1)) begin errors++; $display("FAIL rr_last%0d: got p=%b x=%0d want p=1 x=%0d", e, plot, ox, e * 10 + 1); end
      req[e] = 0; valid = '0; last = '0;
      step();
      checks++; if (plot !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL rr_gap%0d: got p=%b g=%b want 0 000", e, plot, grant); end
    end
    step();
    checks++; if (done !== 1'b1 || grant !== 3'b000) begin errors++; $display("FAIL rr_done: got d=%b g=%b want 1 000", done, grant); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 3'b101;
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL b2b_first: got %b want 001", grant); end
    drive_pix(2'd0, 3, 3, 1, 1'b1);
    step();
    valid = '0; last = '0;
    step();
    step();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL b2b_waiter: got %b want 100", grant); end
    drive_pix(2'd2, 4, 4, 2, 1'b1);
    step();
    req[2] = 0; valid = '0; last = '0;
    step();
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL b2b_return: got %b want 001", grant); end
  endtask

  task automatic test_clip();
    int plots = 0;
    do_reset();
    req[1] = 1;
    step();
    drive_pix(2'd1, 320, 5, 3, 1'b0);
    step();
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL clip_x: got %b want 0", plot); end
    drive_pix(2'd1, 5, 240, 3, 1'b0);
    step();
    checks++; if (plot !== 1'b0) begin errors++; $display("FAIL clip_y: got %b want 0", plot); end
    for (int i = 0; i < 6; i++) begin
      drive_pix(2'd1, 319 - i, 239, 3, 1'b0);
      step();
      if (plot === 1'b1) plots++;
      if (i < 5) begin
        checks++; if (tout !== 1'b0) begin errors++; $display("FAIL clip_early_tout%0d: got %b want 0", i, tout); end
      end
    end
    checks++; if (plots != 6) begin errors++; $display("FAIL clip_plots: got %0d want 6", plots); end
    checks++; if (tout !== 1'b1 || grant !== 3'b000) begin errors++; $display("FAIL clip_count: got t=%b g=%b want 1 000", tout, grant); end
    checks++; if (ox !== 10'd314 || oy !== 9'd239) begin errors++; $display("FAIL clip_edge: got %0d,%0d want 314,239", ox, oy); end
  endtask

  task automatic test_watchdog();
    int plots = 0;
    int touts = 0;
    int tat = -1;
    do_reset();
    req = 3'b011;
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL wd_grant: got %b want 001", grant); end
    for (int i = 0; i < 20; i++) begin
      drive_pix(2'd0, i, i, 5, 1'b0);
      step();
      if (plot === 1'b1) plots++;
      if (tout === 1'b1) begin touts++; tat = i; end
      if (grant === 3'b000) break;
    end
    checks++; if (plots != 8) begin errors++; $display("FAIL wd_plots: got %0d want 8", plots); end
    checks++; if (touts != 1 || tat != 7) begin errors++; $display("FAIL wd_tout: got n=%0d at=%0d want n=1 at=7", touts, tat); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL wd_release: got %b want 000", grant); end
    step();
    checks++; if (tout !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL wd_gap: got t=%b p=%b want 0 0", tout, plot); end
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL wd_next: got %b want 010", grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b100;
    step();
    drive_pix(2'd2, 50, 60, 6, 1'b0);
    step();
    drive_pix(2'd2, 51, 60, 6, 1'b0);
    step();
    checks++; if (plot !== 1'b1 || grant !== 3'b100) begin errors++; $display("FAIL mid_pre: got p=%b g=%b want 1 100", plot, grant); end
    drive_pix(2'd2, 52, 60, 6, 1'b0);
    #2 rst = 1;
    #1;
    checks++; if (grant !== 3'b000 || plot !== 1'b0) begin errors++; $display("FAIL mid_async: got g=%b p=%b want 000 0", grant, plot); end
    checks++; if (ox !== 10'd0 || oy !== 9'd0 || oc !== 3'd0) begin errors++; $display("FAIL mid_xyc: got %0d %0d %0d want 0 0 0", ox, oy, oc); end
    step();
    rst = 0;
    valid = '0;
    req = 3'b111;
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_restart: got %b want 001", grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_back_to_back();
    test_clip();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
# vga_draw_arbiter

Round-robin scheduler that shares the single VGA controller pixel-write port between several draw engines (left paddle, right paddle, ball, score). Each engine requests the port for a burst of pixels (clear-old plus draw-new), and the arbiter grants it for the whole burst. While granted, the engine's pixel stream is registered onto oX/oY/oColour/oPlot. The arbiter also clips off-screen pixels, enforces a burst-length watchdog and signals when all drawing for the current frame is complete.

## Interface
Parameters:
- NUM_REQ, 3: number of requesting draw engines (2..8).
- X_SCREEN_PIXELS, 320: screen width.
- Y_SCREEN_PIXELS, 240: screen height.
- MAX_BURST, 4096: maximum pixels per grant before forced release.

Widths: XW = $clog2(X_SCREEN_PIXELS)+1 and YW = $clog2(Y_SCREEN_PIXELS)+1.

Ports:
- iClock  in  1  system clock; all state changes on its rising edge.
- iReset  in  1  reset; asynchronous and active-high.
- iFrameTick  in  1  one-cycle pulse at the start of each frame.
- iReq  in  NUM_REQ  per-engine request; held high until the burst ends.
- iValid  in  NUM_REQ  per-engine pixel valid.
- iLast  in  NUM_REQ  per-engine last-pixel flag; only meaningful together with iValid.
- iX  in  NUM_REQ*XW  packed x coordinates; engine k occupies bits [k*XW +: XW].
- iY  in  NUM_REQ*YW  packed y coordinates.
- iColour  in  NUM_REQ*3  packed 3-bit colours.
- oGrant  out  NUM_REQ  one-hot grant; all zeros when no engine is granted.
- oX  out  XW  registered pixel x.
- oY  out  YW  registered pixel y.
- oColour  out  3  registered pixel colour.
- oPlot  out  1  registered pixel write enable.
- oFrameDone  out  1  one-cycle pulse when all drawing for the frame is finished.
- oTimeout  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States: IDLE, BURST, GAP.
- Round-robin pointer `ptr`, width $clog2(NUM_REQ).
- Pixel counter `cnt`, width $clog2(MAX_BURST)+1.
- IDLE:
  - If any iReq is set, grant the first set bit searching ptr, ptr+1, ... modulo NUM_REQ.
  - Set oGrant to that one-hot value, clear cnt and go to BURST.
- BURST, with g the granted engine:
  - Each cycle, capture iX/iY/iColour[g] into the outputs.
  - oPlot <= iValid[g] && x < X_SCREEN_PIXELS && y < Y_SCREEN_PIXELS. Off-screen pixels are dropped silently.
  - cnt increments on every iValid[g], including clipped pixels.
  - The burst ends when any of the following holds:
    - iValid[g] && iLast[g] (normal end); the last pixel is still output.
    - iReq[g] falls (abort); no pixel is output that cycle.
    - cnt reaches MAX_BURST-1 on an iValid[g] (watchdog); that pixel is output and oTimeout pulses.
  - At burst end: oGrant <= 0, ptr <= (g+1) mod NUM_REQ, go to GAP.
- GAP:
  - Lasts one cycle with oPlot = 0, then go to IDLE.
  - The GAP cycle guarantees a bubble between engines on the VGA port.
- Frame tracking:
  - Flag `dirty` is set at any grant and cleared when oFrameDone fires.
  - oFrameDone pulses in an IDLE cycle with iReq == 0 and dirty == 1.
  - iFrameTick clears nothing. It only re-arms: if a burst is active at iFrameTick, the burst completes normally.
- Priority and simultaneous events:
  - Requests arriving during BURST or GAP wait; no preemption.
  - Starvation bound: each requester waits at most NUM_REQ-1 bursts.
  - iValid/iLast from non-granted engines are ignored.
  - If the end-of-burst and watchdog conditions occur in the same cycle, it counts as a normal end and oTimeout stays 0.

## Timing
- Reset (asynchronous, immediate): state IDLE, ptr 0, cnt 0, dirty 0. All outputs are 0: oGrant, oX, oY, oColour, oPlot, oFrameDone, oTimeout.
- Reset asserted mid-burst drops the burst at once. After release, arbitration restarts from engine 0.
- Request to grant: iReq high at edge t gives oGrant valid after edge t+1.
- Pixel latency: an engine pixel presented at cycle t (with grant high) appears on oX/oY/oColour/oPlot after edge t+1.
- Minimum spacing between consecutive bursts: the last pixel at t, then GAP, then IDLE, then the next grant visible after edge t+3.
- oFrameDone and oTimeout are exactly one cycle wide.

## Test plan
- Single engine 1 requests, with 4 valid pixels (10,20), (11,20), (12,20), (13,20), colour 7, and iLast on the 4th -> oGrant=3'b010 one cycle after the request; oPlot high for 4 cycles with matching coordinates, each one cycle late; oFrameDone pulses once after iReq drops.
- All three engines request at once from reset -> grants in order 001, 010, 100; each pair of bursts separated by one oPlot=0 GAP cycle plus one IDLE cycle.
- Engine 0 requests again immediately after its burst while engine 2 is waiting -> engine 2 is granted before engine 0.
- Pixels x=320,y=5 and x=5,y=240 inside a burst -> oPlot stays 0 for those pixels; cnt still advances.
- MAX_BURST=8 and an engine streams 20 pixels with no iLast -> 8 plots, then oTimeout pulses once, oGrant clears, and the arbiter moves to the next engine.
- iReset asserted on the 3rd pixel of a burst -> all outputs are 0 in the same cycle; after release, engine 0 has priority.
